// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch read port and a memory-stage read/write
// port onto a single-cycle-strobe memory with variable completion latency.
// Every access is latched at grant and walks IDLE -> ISSUE -> WAIT -> DONE, or
// IDLE -> DONE directly for an out-of-range address. The memory stage wins
// simultaneous requests unless fetch has already been passed over
// STARVE_LIMIT times in a row. A WAIT that outlasts TIMEOUT cycles is aborted
// with an error. All outputs come straight from flops.
module mem_port_arbiter #(
  parameter int DEPTH        = 128,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_ack,
  output logic [63:0] m_rdata,
  output logic        m_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [6:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        busy,
  output logic        owner_m
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          we_q, we_d;

  logic          f_ack_q, f_ack_d;
  logic [63:0]   f_rdata_q, f_rdata_d;
  logic          f_err_q, f_err_d;
  logic          m_ack_q, m_ack_d;
  logic [63:0]   m_rdata_q, m_rdata_d;
  logic          m_err_q, m_err_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [6:0]    mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;

  logic          any_req;
  logic          pick_m;
  logic [63:0]   win_addr;
  logic          addr_ok;
  logic          rdy_hit;
  logic          tmo_hit;
  logic          done_ack;
  logic          done_err;
  logic [63:0]   done_rdata;

  // Arbitration and completion decode shared by next-state and output logic.
  always_comb begin
    any_req  = f_req | m_req;
    // Fetch only wins a tie once it has been passed over STARVE_LIMIT times.
    pick_m   = m_req & ~(f_req & (starve_q == SW'(STARVE_LIMIT)));
    win_addr = pick_m ? m_addr : f_addr;
    addr_ok  = (win_addr < 64'(DEPTH));
    rdy_hit  = (state_q == S_WAIT) & mem_rdy;
    tmo_hit  = (state_q == S_WAIT) & ~mem_rdy & (tcnt_q == TW'(TIMEOUT - 1));
  end

  // State register plus starvation and WAIT-timeout counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d  = addr_ok ? S_ISSUE : S_DONE;
          starve_d = (pick_m & f_req) ? starve_q + SW'(1) : '0;
          tcnt_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (rdy_hit || tmo_hit) begin
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: next value of every registered output, from the transition taken.
  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    done_ack    = 1'b0;
    done_err    = 1'b0;
    done_rdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Fetch is a pure read port: its write flag and data are forced to 0.
          owner_d = pick_m;
          we_d    = pick_m & m_we;
          if (addr_ok) begin
            mem_en_d    = 1'b1;
            mem_we_d    = pick_m & m_we;
            mem_addr_d  = win_addr[6:0];
            mem_wdata_d = pick_m ? m_wdata : '0;
          end else begin
            done_ack = 1'b1;
            done_err = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rdy_hit) begin
          done_ack   = 1'b1;
          done_rdata = we_q ? '0 : mem_rdata;
        end else if (tmo_hit) begin
          done_ack = 1'b1;
          done_err = 1'b1;
        end
      end
      default: begin
      end
    endcase
    // Completion is routed only to the owner; the other port stays quiet.
    f_ack_d   = done_ack & ~owner_d;
    f_err_d   = done_err & ~owner_d;
    f_rdata_d = owner_d ? '0 : done_rdata;
    m_ack_d   = done_ack & owner_d;
    m_err_d   = done_err & owner_d;
    m_rdata_d = owner_d ? done_rdata : '0;
    busy_d    = (state_d != S_IDLE);
  end

  // Output registers; reset clears every output immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      m_ack_q     <= 1'b0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      f_ack_q     <= f_ack_d;
      f_rdata_q   <= f_rdata_d;
      f_err_q     <= f_err_d;
      m_ack_q     <= m_ack_d;
      m_rdata_q   <= m_rdata_d;
      m_err_q     <= m_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign f_rdata   = f_rdata_q;
  assign f_err     = f_err_q;
  assign m_ack     = m_ack_q;
  assign m_rdata   = m_rdata_q;
  assign m_err     = m_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner_m   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory answers each mem_en
// strobe one cycle later (or never, when rdy_en is low); expected completions
// are queued when a request is driven and compared when an ack appears.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_ack;
  logic [63:0] f_rdata;
  logic        f_err;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_ack;
  logic [63:0] m_rdata;
  logic        m_err;
  logic        mem_en;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;
  logic        busy;
  logic        owner_m;

  logic        resp_rdy;
  logic [63:0] resp_data;
  logic        force_rdy;
  logic        rdy_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_m;
    logic [63:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [0:127];
  logic [63:0] mem [0:127];

  int          en_cnt = 0;
  logic [6:0]  last_addr;
  logic        last_we;
  logic [63:0] last_wd;

  mem_port_arbiter #(.DEPTH(128), .STARVE_LIMIT(3), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy), .owner_m(owner_m)
  );

  always #5 clock = ~clock;

  assign mem_rdy   = resp_rdy | force_rdy;
  assign mem_rdata = resp_data;

  function automatic logic [63:0] pat(input int i);
    if (i == 5) return 64'h0f;
    return 64'hA000_0000_0000_0000 | (64'(i) * 64'h0001_0001);
  endfunction

  // Behavioural memory: completes one cycle after the strobe; returns old contents even for writes.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
      resp_rdy  <= 1'b0;
      resp_data <= '0;
    end else begin
      resp_rdy <= 1'b0;
      if (mem_en && rdy_en) begin
        resp_rdy  <= 1'b1;
        resp_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end
    end
  end

  // Strobe monitor: counts mem_en cycles and remembers what was presented.
  always @(posedge clock) begin
    if (mem_en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= mem_addr;
      last_we   <= mem_we;
      last_wd   <= mem_wdata;
    end
  end

  // Drive one request from an idle negedge, score its completion, return at an idle negedge.
  task automatic drive_and_score(input string name, input bit is_m, input bit we,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 input bit chg, input logic [63:0] chg_addr);
    exp_t e;
    exp_t g;
    int   lat;
    bit   exp_en;
    int   en0;
    int   k;
    bit   got;
    e.is_m = is_m;
    if (addr >= 64'd128) begin
      e.err = 1'b1; e.rdata = '0; lat = 1; exp_en = 1'b0;
    end else if (!rdy_en) begin
      e.err = 1'b1; e.rdata = '0; lat = 2 + TIMEOUT; exp_en = 1'b1;
    end else begin
      e.err = 1'b0; e.rdata = we ? 64'd0 : ref_mem[addr[6:0]]; lat = 3; exp_en = 1'b1;
      if (we) ref_mem[addr[6:0]] = wd;
    end
    sb.push_back(e);
    en0 = en_cnt;
    if (is_m) begin
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (chg && k == 1) begin
        if (is_m) m_addr = chg_addr; else f_addr = chg_addr;
      end
      if (f_ack || m_ack) begin
        got = 1'b1;
        g = sb.pop_front();
        checks++;
        if (k !== lat) begin
          errors++; $display("FAIL %s latency: got %0d expected %0d", name, k, lat);
        end
        checks++;
        if ({m_ack, f_ack} !== {g.is_m, ~g.is_m}) begin
          errors++; $display("FAIL %s ack_port: got m_ack=%0b f_ack=%0b expected m_ack=%0b", name, m_ack, f_ack, g.is_m);
        end
        checks++;
        if ((g.is_m ? m_rdata : f_rdata) !== g.rdata) begin
          errors++; $display("FAIL %s rdata: got %h expected %h", name, (g.is_m ? m_rdata : f_rdata), g.rdata);
        end
        checks++;
        if ((g.is_m ? m_err : f_err) !== g.err) begin
          errors++; $display("FAIL %s err: got %0b expected %0b", name, (g.is_m ? m_err : f_err), g.err);
        end
        checks++;
        if ((g.is_m ? {f_err, f_rdata} : {m_err, m_rdata}) !== 65'd0) begin
          errors++; $display("FAIL %s nonowner_quiet: got f_err=%0b f_rdata=%h m_err=%0b m_rdata=%h expected zeros", name, f_err, f_rdata, m_err, m_rdata);
        end
        checks++;
        if (owner_m !== g.is_m) begin
          errors++; $display("FAIL %s owner_m: got %0b expected %0b", name, owner_m, g.is_m);
        end
        if (is_m) m_req = 1'b0; else f_req = 1'b0;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s no_ack: got none within 40 cycles expected ack at %0d", name, lat);
      void'(sb.pop_front());
      f_req = 1'b0; m_req = 1'b0;
    end
    @(negedge clock);
    checks++;
    if ({f_ack, m_ack} !== 2'b00) begin
      errors++; $display("FAIL %s ack_one_cycle: got f_ack=%0b m_ack=%0b expected 0", name, f_ack, m_ack);
    end
    checks++;
    if ((en_cnt - en0) !== int'(exp_en)) begin
      errors++; $display("FAIL %s mem_en_count: got %0d expected %0d", name, en_cnt - en0, exp_en);
    end
    if (exp_en) begin
      checks++;
      if ({last_addr, last_we} !== {addr[6:0], we}) begin
        errors++; $display("FAIL %s mem_addr_we: got %0d/%0b expected %0d/%0b", name, last_addr, last_we, addr[6:0], we);
      end
      if (we) begin
        checks++;
        if (last_wd !== wd) begin
          errors++; $display("FAIL %s mem_wdata: got %h expected %h", name, last_wd, wd);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; force_rdy = 1'b0; rdy_en = 1'b1;
    f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({f_ack, f_err, m_ack, m_err, mem_en, mem_we, busy, owner_m} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {f_ack, f_err, m_ack, m_err, mem_en, mem_we, busy, owner_m});
    end
    checks++;
    if ({f_rdata, m_rdata, mem_wdata, mem_addr} !== '0) begin
      errors++; $display("FAIL reset_data: got f=%h m=%h wd=%h a=%0d expected 0", f_rdata, m_rdata, mem_wdata, mem_addr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, mem_en} !== 2'b00) begin
      errors++; $display("FAIL reset_idle_no_req: got busy=%0b mem_en=%0b expected 0", busy, mem_en);
    end
  endtask

  task automatic test_single_read();
    drive_and_score("m_read_5", 1'b1, 1'b0, 64'd5, 64'd0, 1'b0, 64'd0);
    drive_and_score("f_read_127", 1'b0, 1'b0, 64'd127, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic test_addr_error();
    drive_and_score("m_write_200", 1'b1, 1'b1, 64'd200, 64'h55, 1'b0, 64'd0);
    drive_and_score("f_read_128", 1'b0, 1'b0, 64'd128, 64'd0, 1'b0, 64'd0);
    drive_and_score("m_read_huge", 1'b1, 1'b0, 64'h8000_0000_0000_0003, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic test_timeout();
    rdy_en = 1'b0;
    drive_and_score("m_write_timeout", 1'b1, 1'b1, 64'd14, 64'h12, 1'b0, 64'd0);
    rdy_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    rdy_en = 1'b0;
    f_req = 1'b1; f_addr = 64'd7;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midreset_busy_before: got %0b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({f_ack, f_err, m_ack, m_err, mem_en, mem_we, busy, owner_m, f_rdata, m_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%0b mem_en=%0b f_ack=%0b expected all 0", busy, mem_en, f_ack);
    end
    f_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    rdy_en = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (f_ack || m_ack || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_no_ack: got activity=1 expected 0");
    end
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    drive_and_score("post_reset_read", 1'b0, 1'b0, 64'd7, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic test_write_read();
    drive_and_score("m_write_9", 1'b1, 1'b1, 64'd9, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0);
    drive_and_score("f_read_9", 1'b0, 1'b0, 64'd9, 64'd0, 1'b0, 64'd0);
    drive_and_score("m_read_9", 1'b1, 1'b0, 64'd9, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic test_starvation();
    bit   exp_m [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    int   n;
    int   cyc;
    f_addr = 64'd20; m_addr = 64'd30; m_we = 1'b0; m_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      e.is_m  = exp_m[i];
      e.rdata = exp_m[i] ? ref_mem[30] : ref_mem[20];
      e.err   = 1'b0;
      sb.push_back(e);
    end
    f_req = 1'b1; m_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (f_ack || m_ack) begin
        e = sb.pop_front();
        checks++;
        if ({m_ack, f_ack} !== {e.is_m, ~e.is_m}) begin
          errors++; $display("FAIL starve_order[%0d]: got m_ack=%0b f_ack=%0b expected m=%0b", n, m_ack, f_ack, e.is_m);
        end
        checks++;
        if (owner_m !== e.is_m) begin
          errors++; $display("FAIL starve_owner[%0d]: got %0b expected %0b", n, owner_m, e.is_m);
        end
        checks++;
        if ((e.is_m ? m_rdata : f_rdata) !== e.rdata) begin
          errors++; $display("FAIL starve_rdata[%0d]: got %h expected %h", n, (e.is_m ? m_rdata : f_rdata), e.rdata);
        end
        n++;
        if (n == 8) begin
          f_req = 1'b0; m_req = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL starve_count: got %0d acks expected 8", n);
      f_req = 1'b0; m_req = 1'b0;
      sb.delete();
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL starve_idle_after: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_rdy_idle();
    bit seen;
    force_rdy = 1'b1;
    @(negedge clock);
    force_rdy = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (f_ack || m_ack || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rdy_idle_ignored: got activity=1 expected 0");
    end
    drive_and_score("latched_f_addr", 1'b0, 1'b0, 64'd40, 64'd0, 1'b1, 64'd99);
    drive_and_score("latched_m_addr", 1'b1, 1'b0, 64'd41, 64'd0, 1'b1, 64'd300);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    test_reset();
    test_single_read();
    test_addr_error();
    test_timeout();
    test_reset_mid();
    test_write_read();
    test_starvation();
    test_rdy_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the parameters below.
- DEPTH, 128, memory depth in 64-bit words.
- STARVE_LIMIT, 3, consecutive memory-stage grants allowed while fetch waits.
- TIMEOUT, 16, WAIT cycles before the access is aborted.
REQ-002 The block SHALL have the ports below, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  64  fetch word address.
- f_ack  out  1  one-cycle completion pulse for fetch.
- f_rdata  out  64  fetch read data; valid while f_ack=1.
- f_err  out  1  fetch address/timeout error; valid while f_ack=1.
- m_req  in  1  memory-stage request.
- m_we  in  1  memory-stage write (1) or read (0).
- m_addr  in  64  memory-stage word address (valE or valA).
- m_wdata  in  64  memory-stage write data.
- m_ack  out  1  one-cycle completion pulse for the memory stage.
- m_rdata  out  64  memory-stage read data; valid while m_ack=1.
- m_err  out  1  memory-stage error; valid while m_ack=1.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  7  memory word index.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data; valid while mem_rdy=1.
- mem_rdy  in  1  memory completion, one cycle.
- busy  out  1  high when state is not IDLE.
- owner_m  out  1  current grant: 1 = memory stage, 0 = fetch.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-004 All outputs SHALL be registered.
REQ-005 In IDLE with at least one request, the block SHALL pick a winner, latch its address, write data and write flag, and set owner_m.
REQ-006 The memory stage SHALL win a simultaneous request unless starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-007 starve_cnt SHALL increment on each memory-stage grant made while f_req=1, and SHALL clear on any fetch grant or on any arbitration with f_req=0.
REQ-008 If the latched address is >= DEPTH, the FSM SHALL go IDLE->DONE with err=1, without asserting mem_en.
REQ-009 If the latched address is < DEPTH, the FSM SHALL go IDLE->ISSUE, driving mem_en=1, mem_addr=addr[6:0], mem_we=latched we and mem_wdata=latched data.
REQ-010 The FSM SHALL go ISSUE->WAIT unconditionally, with mem_en=0 in WAIT.
REQ-011 In WAIT, mem_rdy=1 SHALL move the FSM to DONE, capturing mem_rdata for reads and 0 for writes.
REQ-012 After TIMEOUT consecutive WAIT cycles without mem_rdy, the FSM SHALL go to DONE with err=1 and rdata=0.
REQ-013 In DONE, the block SHALL assert the owner's ack for exactly one cycle, with rdata and err; the non-owner's ack, rdata and err SHALL stay 0.
REQ-014 The FSM SHALL go DONE->IDLE unconditionally, and requests SHALL be ignored during DONE.
REQ-015 Minimum latency SHALL be:
- 3 clocks from the IDLE edge that samples req to the ack cycle, when mem_rdy arrives on the first WAIT cycle.
- 1 clock for an address error.
REQ-016 Requesters SHALL hold req, addr, we and wdata stable until ack, and deassert req in the cycle after ack; the block latches at grant, so later input changes do not affect the access in flight.
REQ-017 A request is not granted twice: back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-018 mem_rdy outside WAIT SHALL be ignored.
REQ-019 A write with m_we=1 SHALL return m_rdata=0.
REQ-020 f_req SHALL be treated as read-only; there is no fetch write path.

Reset
REQ-021 Asserting reset SHALL immediately set state to IDLE, clear starve_cnt and the timeout counter, and drive all outputs to 0.
REQ-022 Reset asserted mid-access (ISSUE or WAIT) SHALL abandon the access with no ack; memory contents after an issued write are undefined.
REQ-023 After reset deasserts, the first arbitration SHALL occur on the first posedge with a request.

Verification
REQ-024 A single m_req read at m_addr=5, with mem_rdy one cycle after mem_en and mem_rdata=64'h0f -> mem_en one pulse with mem_addr=5, then m_ack one pulse 3 clocks after grant with m_rdata=64'h0f and m_err=0.
REQ-025 f_req and m_req held continuously -> grant order M,M,M,F,M,M,M,F, with owner_m matching at each ack.
REQ-026 m_req write at m_addr=200 -> no mem_en, and m_ack with m_err=1 one clock after grant.
REQ-027 m_req write at m_addr=14, m_wdata=64'h12, with mem_rdy never asserted -> after 16 WAIT cycles, m_ack=1, m_err=1, m_rdata=0.
REQ-028 Reset pulsed during WAIT of an f_req read -> all outputs 0 at once, no f_ack, and a new f_req after reset completes normally.
REQ-029 mem_rdy pulsed while IDLE, plus f_addr changed after grant -> no ack generated, and mem_addr equals the address latched at grant.
